// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and select encodings for the multicycle control path
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_LUI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRWB,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_dec.sv
// rtl/imm_src_dec.sv - combinational opcode to immediate-format decode
module imm_src_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = IMM_U;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for the shared-memory multicycle RV32I core
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit MEM_WAIT     = 1'b1,
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             Illegal,
  output logic             InstrDone,
  output logic [CNT_W-1:0] Instret
);

  state_t state, next;
  logic   ready;

  assign ready = MemReady | ~MEM_WAIT;

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (ImmSrc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      Instret <= '0;
    end else begin
      state <= next;
      if (InstrDone) Instret <= Instret + CNT_W'(1);
    end
  end

  always_comb begin
    next      = state;
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    Illegal   = 1'b0;
    InstrDone = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 is written only in the ready cycle so a stalled fetch cannot advance PC twice
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = ready;
        PCUpdate  = ready;
        if (ready) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_RTYPE:          next = S_EXECUTER;
          OP_ITYPE:          next = S_EXECUTEI;
          OP_BRANCH:         next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          OP_JALR:           next = S_JALR;
          OP_LUI:            next = S_LUI;
          default:           next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (ready) begin
          InstrDone = 1'b1;
          next      = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        next      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUOp     = ALUOP_BR;
        Branch    = 1'b1;
        InstrDone = 1'b1;
        next      = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
        next     = S_ALUWB;
      end
      S_JALR: begin
        // target goes to PC directly; the link value is rebuilt from OldPC+4 next cycle
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCUpdate  = 1'b1;
        next      = S_JALRWB;
      end
      S_JALRWB: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        next      = S_FETCH;
      end
      S_ILLEGAL: begin
        Illegal = 1'b1;
        next    = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I core; replaces the single-cycle main decoder when the core shares one memory port for instruction and data.
- Sequences FETCH/DECODE/execute/writeback per instruction and drives every datapath select and strobe.
- Supports an optional memory wait handshake and an illegal-opcode trap.
- Counts retired instructions.

Parameters:
- MEM_WAIT, 1: 1 = FETCH/MEMREAD/MEMWRITE hold until MemReady; 0 = MemReady ignored (treated as 1).
- ILLEGAL_HALT, 1: 1 = ILLEGAL state is sticky until reset; 0 = ILLEGAL returns to FETCH after one cycle.
- CNT_W, 32: width of the Instret counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  opcode from the instruction register.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access requested.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  instruction register and OldPC load.
- PCUpdate  out  1  unconditional PC load.
- Branch  out  1  PC load gated by the datapath compare.
- RegWrite  out  1  register file write.
- MemWrite  out  1  data store.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 reg, 11 = zero.
- ALUSrcB  out  2  ALU B select: 00 = rs2 reg, 01 = Imm, 10 = constant 4.
- ALUOp  out  2  ALU decode class: 00 = add, 01 = branch compare, 10 = funct decode.
- ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U. Combinational from op; 000 for unknown opcodes.
- Illegal  out  1  high while in ILLEGAL.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.
- Instret  out  CNT_W  count of retired instructions.

Behaviour:
- Registered state, Moore outputs; ImmSrc is the only output decoded from op.
- Reset is asynchronous: state = FETCH, Instret = 0. While in FETCH immediately after reset, outputs are the FETCH values. All outputs not listed for a state are 0.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=(MemReady|~MEM_WAIT).
  - Go to DECODE when ready, else stay. PC must never increment twice for one fetch.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - anything else -> ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Go to MEMWB when ready, else stay.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Go to FETCH.
- MEMWRITE:
  - MemReq=1, AdrSrc=1, ResultSrc=00, MemWrite=1, held for the whole access.
  - When ready: InstrDone=1, go to FETCH; else stay.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1. Go to JALRWB.
- JALRWB: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1, InstrDone=1. Go to FETCH.
- ILLEGAL: Illegal=1, no strobes, InstrDone=0, Instret not incremented. Stays if ILLEGAL_HALT=1, else returns to FETCH.
- Instret increments by 1 on each cycle with InstrDone=1 and wraps modulo 2^CNT_W.
- Reset asserted mid-instruction (including during a wait): state returns to FETCH immediately; any pending access is abandoned.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum
  - opcode constants
  - encodings for ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc
- Sub-module imm_src_dec: the combinational op -> ImmSrc decode, reused by the single-cycle core.

Test Plan:
- MEM_WAIT=1, lw with MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD -> IRWrite and PCUpdate are high only in the ready cycle; 5 states plus 5 wait cycles total; InstrDone in MEMWB; Instret=1.
- add, then addi, then sw with MemReady tied to 1 -> 4, 4, 4 cycles; MemWrite high exactly 1 cycle; Instret=3.
- jal then jalr -> JAL state PCUpdate=1, ResultSrc=00; JALRWB RegWrite=1, ResultSrc=10, ALUSrcA=01, ALUSrcB=10.
- lui -> ALUSrcA=11, ImmSrc=100; beq -> Branch=1 for 1 cycle, ALUOp=01, 3 cycles total.
- op=0000000 -> with ILLEGAL_HALT=1, Illegal stays high 10 cycles and Instret is frozen; with ILLEGAL_HALT=0, Illegal pulses 1 cycle, then FETCH.
- Reset asserted in MEMWRITE mid-wait, asynchronously between edges -> state=FETCH and Instret=0 without a clock edge; MemWrite drops immediately.
